mmio_bridge: RTL
================

// Module: mmio_bridge
// PURPOSE
//  Memory-mapped I/O slave on the CPU memory bus, beside the RAM read path.
//  Decodes mem_cmd/mem_addr for the I/O region.
//  - Switch port (SW_ADDR): registered read data plus an output enable for the shared read_data tri-state.
//  - LED port (LED_ADDR): holds the last written value.
//  - Flags any I/O-region access that hits neither port.
// PARAMETERS
//  SW_ADDR          9'h140  read-only switch register address
//  LED_ADDR         9'h100  write-only LED register address
//  SW_W             8       switch bits exposed (zero-extended to 16)
//  LED_W            8       LED bits driven
//  DEBOUNCE_CYCLES  16      stable cycles needed before a switch change is accepted (debounce build only)
// PORTS
//  clk          in   1     system clock, rising edge
//  reset        in   1     synchronous, active-high
//  mem_cmd      in   2     00 NONE, 01 READ, 10 WRITE, 11 reserved (treated as NONE)
//  mem_addr     in   9     bus address; I/O region = mem_addr[8]==1
//  mem_wdata    in   16    write data from CPU
//  sw_in        in   SW_W  raw asynchronous switch inputs
//  io_rdata     out  16    read data; valid only while io_rdata_oe=1
//  io_rdata_oe  out  1     enable for the read_data tri-state
//  led_out      out  LED_W LED register contents
//  io_err       out  1     sticky: unmapped I/O access seen
// BEHAVIOUR
//  - Reset values:
//    - io_rdata=0, io_rdata_oe=0, led_out=0, io_err=0.
//    - Synchronizer and debounce state = 0; response FSM = IDLE.
//  - sw_in path: two-flop synchronizer into sw_sync. Reads return sw_stable (see CONFIGURATION).
//  - Response FSM, read latency is 1 cycle (matches the synchronous RAM):
//    - IDLE: if READ && addr==SW_ADDR at edge N:
//      - capture io_rdata={ {16-SW_W{0}}, sw_stable } at edge N.
//      - go to RESP; io_rdata_oe=1 for the cycle after edge N.
//    - RESP: at edge N+1:
//      - if another SW read is present, recapture and stay in RESP (oe held high, back-to-back reads).
//      - otherwise return to IDLE; oe=0 and io_rdata holds its last value.
//  - LED write: WRITE && addr==LED_ADDR at an edge -> led_out<=mem_wdata[LED_W-1:0] at that edge.
//    Upper wdata bits are ignored. A WRITE to SW_ADDR is ignored.
//  - READ of LED_ADDR: no response; oe stays 0.
//  - io_err:
//    - set at the edge where mem_cmd is READ or WRITE, mem_addr[8]==1, and addr is neither SW_ADDR nor LED_ADDR.
//    - stays set until reset.
//    - Accesses with mem_addr[8]==0 (RAM region) never affect this block.
//  - Single bus master: READ and WRITE cannot coincide. cmd 11 is a no-op with no error.
//  - Reset mid-read: reset takes priority at the edge. The FSM goes to IDLE and oe=0 the following cycle,
//    even if a READ is present in the same cycle.
// CONFIGURATION
//  Macro MMIO_DEBOUNCE_EN.
//  - Defined: sw_debounce instance per bit. sw_stable[i] takes sw_sync[i] only after sw_sync[i] differs
//    from sw_stable[i] for DEBOUNCE_CYCLES consecutive cycles. The counter clears on any return to equality.
//    Counter width = $clog2(DEBOUNCE_CYCLES+1).
//  - Undefined: sw_stable = sw_sync (2-cycle synchronizer latency only); DEBOUNCE_CYCLES is unused.
// STRUCTURE
//  - Package mmio_pkg: MEM_NONE/MEM_READ/MEM_WRITE command constants, default SW_ADDR/LED_ADDR,
//    response FSM state encoding (IDLE, RESP).
//  - Sub-module sw_debounce (one bit, parameter DEBOUNCE_CYCLES), instantiated SW_W times under MMIO_DEBOUNCE_EN.
//  - Address decode and response FSM stay in mmio_bridge. The tri-state driver stays at top level.
// TESTING
//  1. Reset 2 cycles, then idle -> io_rdata_oe=0, led_out=0, io_err=0.
//  2. sw_in=8'hA5, wait 3 cycles (plus DEBOUNCE_CYCLES+1 with MMIO_DEBOUNCE_EN), READ 9'h140
//     -> next cycle oe=1, io_rdata=16'h00A5; following cycle oe=0.
//  3. WRITE 9'h100 wdata=16'h12C3 -> led_out=8'hC3 after that edge.
//     Then READ 9'h100 -> oe stays 0, io_err stays 0.
//  4. READ 9'h140 on 3 consecutive cycles while sw_in changes 8'h01->8'h02 (no debounce)
//     -> oe high 3 cycles, data tracks sw_sync per capture.
//  5. WRITE 9'h1F0 -> io_err=1 and stays 1 through later valid accesses.
//     READ 9'h0F0 (RAM region) -> no oe, no error change.
//  6. MMIO_DEBOUNCE_EN: sw_in bit0 toggled for DEBOUNCE_CYCLES-1 cycles then restored -> read returns the old value.
//     Also: reset asserted in the same cycle as a READ 9'h140 -> oe=0 next cycle.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: bus command
// encodings, default register addresses and the response FSM states.
package mmio_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [8:0] SW_ADDR_DEFAULT  = 9'h140;
  localparam logic [8:0] LED_ADDR_DEFAULT = 9'h100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/sw_debounce.sv
// One-bit debouncer: the stable value only follows the synchronized input
// after it has disagreed for DEBOUNCE_CYCLES consecutive cycles. Any return
// to agreement restarts the count.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O slave for the CPU memory bus. Decodes the I/O region
// (mem_addr[8]==1): a read-only switch register with one-cycle registered
// read data plus tri-state enable, a write-only LED register, and a sticky
// error flag for unmapped I/O accesses. Define MMIO_DEBOUNCE_EN to add a
// per-bit debouncer behind the switch synchronizer.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [8:0] SW_ADDR         = SW_ADDR_DEFAULT,
  parameter logic [8:0] LED_ADDR        = LED_ADDR_DEFAULT,
  parameter int         SW_W            = 8,
  parameter int         LED_W           = 8,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mem_cmd,
  input  logic [8:0]       mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [SW_W-1:0]  sw_in,
  output logic [15:0]      io_rdata,
  output logic             io_rdata_oe,
  output logic [LED_W-1:0] led_out,
  output logic             io_err
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cfg
    $error("mmio_bridge: DEBOUNCE_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Switch input path
  // ---------------------------------------------------------------------
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic [SW_W-1:0] sw_stable;

  // Two-flop synchronizer for the asynchronous switch inputs.
  // NOTE: non-blocking assignments make both flops sample their pre-edge
  // inputs; blocking here would collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  for (genvar i = 0; i < SW_W; i++) begin : g_debounce
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (sw_sync[i]),
      .stable(sw_stable[i])
    );
  end
`else
  assign sw_stable = sw_sync;
`endif

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic is_access;
  logic sw_read;
  logic led_write;
  logic unmapped;

  assign is_access = (mem_cmd == MEM_READ) || (mem_cmd == MEM_WRITE);
  assign sw_read   = (mem_cmd == MEM_READ)  && (mem_addr == SW_ADDR);
  assign led_write = (mem_cmd == MEM_WRITE) && (mem_addr == LED_ADDR);
  assign unmapped  = is_access && mem_addr[8] &&
                     (mem_addr != SW_ADDR) && (mem_addr != LED_ADDR);

  // Only the low LED_W write-data bits reach the LED register.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^(mem_wdata >> LED_W);

  // ---------------------------------------------------------------------
  // Response FSM
  // ---------------------------------------------------------------------
  resp_state_t state_q;
  resp_state_t state_d;
  logic        capture;

  // State register; reset wins over any bus command in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, capture strobe and output enable.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    io_rdata_oe = (state_q == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (sw_read) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (sw_read) capture = 1'b1;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data register: holds its last value when no capture occurs.
  always_ff @(posedge clk) begin
    if (reset)        io_rdata <= '0;
    else if (capture) io_rdata <= 16'(sw_stable);
  end

  // ---------------------------------------------------------------------
  // LED register and error flag
  // ---------------------------------------------------------------------

  // LED register loads on a write to LED_ADDR.
  always_ff @(posedge clk) begin
    if (reset)          led_out <= '0;
    else if (led_write) led_out <= mem_wdata[LED_W-1:0];
  end

  // Sticky unmapped-access flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)         io_err <= 1'b0;
    else if (unmapped) io_err <= 1'b1;
  end

endmodule
